// File: rtl/rst_requester.sv
// Reset-request initiator: debounced button, software pulse and optional watchdog (RST_WDT_EN)
// merged into a stretched active-low request with sticky cause bits that survive requested resets.
module rst_requester #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STRETCH_CYCLES  = 8,
  parameter int unsigned WDT_TIMEOUT     = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ib,
  input  logic       sw_req,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  input  logic       cause_clr,
  output logic       rst_req_ob,
  output logic [2:0] cause
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned STR_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam int unsigned WDT_W = $clog2(WDT_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             state_q;
  logic [STR_W-1:0]   str_cnt_q;
  logic               rst_req_q;

  logic               sync1_q, sync2_q;
  logic               btn_stable_q, btn_stable_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               btn_trig_q, btn_trig_d;
  logic               wdt_fire;
  logic [2:0]         trig;
  logic [2:0]         cause_q, cause_d;

  // The level must differ for DEBOUNCE_CYCLES counted cycles plus the accepting cycle.
  always_comb begin
    db_cnt_d     = '0;
    btn_stable_d = btn_stable_q;
    btn_trig_d   = 1'b0;
    if (sync2_q != btn_stable_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
        btn_stable_d = sync2_q;
        btn_trig_d   = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

`ifdef RST_WDT_EN
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

  // Only runs while idle, so a timeout cannot re-trigger during its own request.
  always_comb begin
    wdt_cnt_d = '0;
    wdt_fire  = 1'b0;
    if (wdt_en && !wdt_kick && (state_q == IDLE)) begin
      if (wdt_cnt_q == WDT_W'(WDT_TIMEOUT - 1)) begin
        wdt_fire = 1'b1;
      end else begin
        wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
    end
  end
`else
  logic [WDT_W+1:0] unused_wdt;
  assign unused_wdt = {wdt_en, wdt_kick, {WDT_W{1'b0}}};
  assign wdt_fire   = 1'b0;
`endif

  assign trig    = {sw_req, wdt_fire, btn_trig_q};
  assign cause_d = (cause_clr ? 3'b000 : cause_q) | trig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      btn_stable_q <= 1'b1;
      db_cnt_q     <= '0;
      btn_trig_q   <= 1'b0;
      cause_q      <= 3'b000;
    end else begin
      sync1_q      <= btn_ib;
      sync2_q      <= sync1_q;
      btn_stable_q <= btn_stable_d;
      db_cnt_q     <= db_cnt_d;
      btn_trig_q   <= btn_trig_d;
      cause_q      <= cause_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      str_cnt_q <= '0;
      rst_req_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (|trig) begin
            state_q   <= ASSERT;
            str_cnt_q <= STR_W'(STRETCH_CYCLES - 1);
            rst_req_q <= 1'b0;
          end
        end
        ASSERT: begin
          if (str_cnt_q == '0) begin
            if (!btn_stable_q) begin
              state_q <= HOLD;
            end else begin
              state_q   <= IDLE;
              rst_req_q <= 1'b1;
            end
          end else begin
            str_cnt_q <= str_cnt_q - STR_W'(1);
          end
        end
        HOLD: begin
          // Button still held after the stretch: keep the request until release is debounced.
          if (btn_stable_q) begin
            state_q   <= IDLE;
            rst_req_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          rst_req_q <= 1'b1;
        end
      endcase
    end
  end

  assign rst_req_ob = rst_req_q;
  assign cause      = cause_q;

endmodule

// File: tb/tb_rst_requester.sv
// Randomized and directed bench for rst_requester against a timestamp-based reference model.
module tb_rst_requester;

  localparam int DB  = 16;
  localparam int STR = 8;
  localparam int WDT = 32;
  localparam int HD  = DB + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_ib = 1'b1;
  logic       sw_req = 1'b0;
  logic       wdt_en = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       cause_clr = 1'b0;
  logic       rst_req_ob;
  logic [2:0] cause;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  rst_requester #(
    .DEBOUNCE_CYCLES(DB),
    .STRETCH_CYCLES (STR),
    .WDT_TIMEOUT    (WDT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_ib    (btn_ib),
    .sw_req    (sw_req),
    .wdt_en    (wdt_en),
    .wdt_kick  (wdt_kick),
    .cause_clr (cause_clr),
    .rst_req_ob(rst_req_ob),
    .cause     (cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: request is a time window [start, ...) that ends once it is at
  // least STR edges old and the debounced button is released; debounce is a
  // sliding window over raw button history.
  bit       m_active = 1'b0;
  int       m_start = 0;
  logic [2:0] m_cause = 3'b000;
  logic [2:0] m_trig;
  bit       m_stable = 1'b1;
  bit       m_btn_trig = 1'b0;
  int       m_wdt_last = 0;
  bit       m_hist [HD];
  bit       flip;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_active   = 1'b0;
      m_cause    = 3'b000;
      m_stable   = 1'b1;
      m_btn_trig = 1'b0;
      m_wdt_last = cyc;
      for (int k = 0; k < HD; k++) m_hist[k] = 1'b1;
    end else begin
      m_trig = {sw_req, 1'b0, m_btn_trig};
`ifdef RST_WDT_EN
      if (wdt_en && !wdt_kick && !m_active && (cyc - m_wdt_last == WDT)) m_trig[1] = 1'b1;
      if (!wdt_en || wdt_kick || m_active || m_trig[1]) m_wdt_last = cyc;
`endif
      m_cause = (cause_clr ? 3'b000 : m_cause) | m_trig;
      if (!m_active) begin
        if (m_trig != 3'b000) begin
          m_active = 1'b1;
          m_start  = cyc;
        end
      end else if ((cyc - m_start >= STR) && m_stable) begin
        m_active = 1'b0;
      end
      flip = 1'b1;
      for (int k = 1; k <= DB + 1; k++) if (m_hist[k] == m_stable) flip = 1'b0;
      m_btn_trig = flip && m_stable;
      if (flip) m_stable = !m_stable;
      for (int k = HD - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = btn_ib;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_req", {31'd0, rst_req_ob}, {31'd0, !m_active});
      check("model_cause", {29'd0, cause}, {29'd0, m_cause});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      if (!rst_req_ob) lows++;
      tick();
    end
  endtask

  int lows, first, fall, rise, kick_edge, hold_len;

  initial begin
    for (int k = 0; k < HD; k++) m_hist[k] = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    check("reset_req", {31'd0, rst_req_ob}, 32'd1);
    check("reset_cause", {29'd0, cause}, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Software pulse: 8 low edges, cause=100.
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    count_low(14, lows);
    check("sw_low_len", lows, 32'd8);
    check("sw_cause", {29'd0, cause}, 32'b100);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    check("clr_cause", {29'd0, cause}, 32'd0);

    // 10-cycle glitch is filtered.
    btn_ib = 1'b0;
    repeat (10) tick();
    btn_ib = 1'b1;
    count_low(40, lows);
    check("glitch_low", lows, 32'd0);
    check("glitch_cause", {29'd0, cause}, 32'd0);

    // Button held 100 cycles.
    btn_ib = 1'b0;
    first = cyc + 1;
    fall = -1;
    for (int i = 0; i < 60 && fall < 0; i++) begin
      tick();
      if (!rst_req_ob) fall = cyc;
    end
    check("btn_fall_lat", fall - first, 32'd19);
    check("btn_cause", {29'd0, cause}, 32'b001);
    while (cyc < first + 99) tick();
    btn_ib = 1'b1;
    first = cyc + 1;
    rise = -1;
    for (int i = 0; i < 60 && rise < 0; i++) begin
      tick();
      if (rst_req_ob) rise = cyc;
    end
    check("btn_rise_lat", rise - first, 32'd19);
    repeat (5) tick();

    // Software request and clear together; retrigger does not stretch.
    sw_req = 1'b1;
    cause_clr = 1'b1;
    tick();
    sw_req = 1'b0;
    cause_clr = 1'b0;
    check("swclr_cause", {29'd0, cause}, 32'b100);
    lows = 0;
    for (int i = 0; i < 14; i++) begin
      if (!rst_req_ob) lows++;
      sw_req = (i == 2);
      tick();
    end
    sw_req = 1'b0;
    check("retrig_len", lows, 32'd8);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;

    // Watchdog: serviced, then starved.
    wdt_en = 1'b1;
    lows = 0;
    kick_edge = 0;
    for (int i = 0; i < 200; i++) begin
      wdt_kick = (i % 20 == 0);
      tick();
      if (i == 180) kick_edge = cyc;
      if (!rst_req_ob) lows++;
    end
    wdt_kick = 1'b0;
    check("wdt_kicked_low", lows, 32'd0);
    fall = -1;
    lows = 0;
    while (cyc < kick_edge + 80) begin
      tick();
      if (!rst_req_ob) begin
        lows++;
        if (fall < 0) fall = cyc;
      end
    end
    wdt_en = 1'b0;
`ifdef RST_WDT_EN
    check("wdt_low_len", lows, 32'd8);
    check("wdt_fall_lat", fall - kick_edge, 32'd32);
    check("wdt_cause", {29'd0, cause}, 32'b010);
`else
    check("wdt_off_low", lows, 32'd0);
    check("wdt_off_cause", {29'd0, cause}, 32'd0);
`endif

    // Reset mid-request.
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check("abort_req", {31'd0, rst_req_ob}, 32'd1);
    check("abort_cause", {29'd0, cause}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Random traffic against the model.
    hold_len = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold_len == 0) begin
        btn_ib = ~btn_ib;
        hold_len = $urandom_range(1, 45);
      end else begin
        hold_len--;
      end
      sw_req    = ($urandom_range(0, 39) == 0);
      wdt_kick  = ($urandom_range(0, 39) == 0);
      cause_clr = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) wdt_en = ~wdt_en;
      rst_n     = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    sw_req = 1'b0;
    wdt_kick = 1'b0;
    cause_clr = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
